// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and baud divisor helper
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Integer-truncated clocks per line bit; the receiver will reuse this.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with wrap-bit pointers feeding the transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_unit.sv
// rtl/uart_tx_unit.sv - FIFO-buffered 8N1 UART transmitter driving the CPU uart_tx pin
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int              DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int              CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((DIV > 1) ? DIV - 2 : 0);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tick;
  logic             pop;
  logic             push;

  assign tick    = (cnt == CNT_LAST);
  assign pop     = !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && tick && (bit_idx == STOP_LAST)));
  assign push    = wr_en && (!fifo_full || pop);
  assign full    = fifo_full;
  assign tx_busy = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= IDLE_LEVEL;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lands on the final stop-bit cycle.
      tx_done <= (state == STOP) && (bit_idx == STOP_LAST) && (cnt == CNT_PRE);
      if (wr_en && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          cnt     <= '0;
          uart_tx <= IDLE_LEVEL;
          if (pop) begin
            shift   <= head;
            uart_tx <= !IDLE_LEVEL;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              uart_tx <= IDLE_LEVEL;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (bit_idx != STOP_LAST) begin
              bit_idx <= bit_idx + 1'b1;
            end else if (pop) begin
              bit_idx <= '0;
              shift   <= head;
              uart_tx <= !IDLE_LEVEL;
              state   <= START;
            end else begin
              bit_idx <= '0;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb/tb_uart_tx_unit.sv - directed self-checking bench for uart_tx_unit at DIV=16, FIFO_DEPTH=4
module tb_uart_tx_unit;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       tx_busy;
  logic       tx_done;
  logic       overflow;
  logic       uart_tx;

  int n_checks;
  int n_fail;
  int cyc;

  int         f_start[$];
  logic [7:0] f_data[$];
  bit         f_ok[$];
  int         done_q[$];

  uart_tx_unit #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .overflow (overflow),
    .uart_tx  (uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Independent line receiver: 16 clocks per bit, data sampled mid-bit,
  // any line change off a bit boundary marks the frame bad.
  initial begin
    bit         in_frame;
    bit         ok;
    int         fs;
    int         off;
    logic       prev;
    logic [7:0] d;
    in_frame = 0; ok = 1; fs = 0; off = 0; prev = 1'b1; d = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
      end else begin
        if (tx_done === 1'b1) done_q.push_back(cyc);
        if (!in_frame) begin
          if (prev === 1'b1 && uart_tx === 1'b0) begin
            in_frame = 1; fs = cyc; ok = 1;
          end
        end else begin
          off = cyc - fs;
          if (uart_tx !== prev && (off % 16) != 0) ok = 0;
        end
        if (in_frame) begin
          off = cyc - fs;
          if ((off % 16) == 8) begin
            if (off / 16 == 0) begin
              if (uart_tx !== 1'b0) ok = 0;
            end else if (off / 16 <= 8) begin
              d[off/16-1] = uart_tx;
            end else if (uart_tx !== 1'b1) begin
              ok = 0;
            end
          end
          if (off == 159) begin
            f_start.push_back(fs); f_data.push_back(d); f_ok.push_back(ok);
            in_frame = 0;
          end
        end
      end
      prev = uart_tx;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_logs();
    f_start.delete(); f_data.delete(); f_ok.delete(); done_q.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int n;
    wait_cyc(10);
    clear_logs();
    n = cyc;
    write_byte(8'h55);
    n_checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_n1: tx=%b busy=%b want tx=1 busy=1", uart_tx, tx_busy); end
    @(negedge clk);
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL single_start_low: got %b want 0 at cycle %0d", uart_tx, cyc); end
    wait_cyc(n + 161);
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_stop: got %b want 1", tx_busy); end
    @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin n_fail++; $display("FAIL single_busy_drop: busy=%b tx=%b want 0,1 at cycle %0d", tx_busy, uart_tx, cyc); end
    n_checks++; if (f_data.size() != 1 || f_data[0] !== 8'h55 || f_ok[0] != 1 || f_start[0] != n + 2) begin
      n_fail++; $display("FAIL single_frame: frames=%0d data=%h start=%0d want 1 frame 55 start %0d", f_data.size(), (f_data.size() > 0) ? f_data[0] : 8'h00, (f_start.size() > 0) ? f_start[0] : -1, n + 2);
    end
    n_checks++; if (done_q.size() != 1 || done_q[0] != 171) begin n_fail++; $display("FAIL single_done: pulses=%0d first=%0d want 1 at 171", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_logs();
    n = cyc;
    write_byte(8'hA5);
    write_byte(8'h3C);
    wait_cyc(n + 324);
    n_checks++; if (f_data.size() != 2 || f_data[0] !== 8'hA5 || f_data[1] !== 8'h3C || !f_ok[0] || !f_ok[1]) begin
      n_fail++; $display("FAIL b2b_data: frames=%0d want A5,3C clean", f_data.size());
    end
    n_checks++; if (f_start.size() != 2 || f_start[0] != n + 2 || f_start[1] != n + 162) begin
      n_fail++; $display("FAIL b2b_starts: got %0d,%0d want %0d,%0d", (f_start.size() > 0) ? f_start[0] : -1, (f_start.size() > 1) ? f_start[1] : -1, n + 2, n + 162);
    end
    n_checks++; if (done_q.size() != 2 || done_q[0] != n + 161 || done_q[1] - done_q[0] != 160) begin
      n_fail++; $display("FAIL b2b_done: pulses=%0d first=%0d want 2 from %0d spaced 160", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, n + 161);
    end
  endtask

  task automatic test_overflow();
    int n;
    bit good;
    clear_logs();
    n = cyc;
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    write_byte(8'h04);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_three_queued_full: got %b want 0", full); end
    write_byte(8'h05);
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_four_queued: full=%b ovf=%b want 1,0", full, overflow); end
    write_byte(8'h06);
    n_checks++; if (full !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_dropped: full=%b ovf=%b want 1,1", full, overflow); end
    wait_cyc(n + 801);
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_last: got %b want 1", tx_busy); end
    @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end: busy=%b ovf=%b want 0,1", tx_busy, overflow); end
    good = (f_data.size() == 5);
    for (int k = 0; k < 5 && good; k++)
      if (f_data[k] !== 8'(k + 1) || !f_ok[k] || f_start[k] != n + 2 + 160 * k) good = 0;
    n_checks++; if (!good) begin n_fail++; $display("FAIL ovf_frames: frames=%0d want 01..05 every 160 cycles", f_data.size()); end
    pulse_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared_by_reset: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    int n;
    bit good;
    clear_logs();
    n = cyc;
    write_byte(8'h11);
    write_byte(8'h12);
    write_byte(8'h13);
    write_byte(8'h14);
    write_byte(8'h15);
    wait_cyc(n + 161);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullpop_pre: full=%b want 1", full); end
    write_byte(8'h16);
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_post: full=%b ovf=%b want 1,0", full, overflow); end
    wait_cyc(n + 963);
    good = (f_data.size() == 6);
    for (int k = 0; k < 6 && good; k++)
      if (f_data[k] !== 8'(8'h11 + k) || !f_ok[k] || f_start[k] != n + 2 + 160 * k) good = 0;
    n_checks++; if (!good) begin n_fail++; $display("FAIL fullpop_frames: frames=%0d want 11..16 every 160 cycles", f_data.size()); end
    n_checks++; if (done_q.size() != 6 || overflow !== 1'b0 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_end: pulses=%0d ovf=%b busy=%b want 6,0,0", done_q.size(), overflow, tx_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_logs();
    n = cyc;
    write_byte(8'hF0);
    wait_cyc(n + 70);
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_bit3_low: got %b want 0", uart_tx); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_line_async: got %b want 1", uart_tx); end
    n_checks++; if (tx_busy !== 1'b0 || full !== 1'b0 || tx_done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: busy=%b full=%b done=%b ovf=%b want all 0", tx_busy, full, tx_done, overflow);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    n = cyc;
    write_byte(8'h81);
    wait_cyc(n + 163);
    n_checks++; if (f_data.size() != 1 || f_data[0] !== 8'h81 || !f_ok[0] || f_start[0] != n + 2) begin
      n_fail++; $display("FAIL midrst_new_frame: frames=%0d data=%h want one clean 81", f_data.size(), (f_data.size() > 0) ? f_data[0] : 8'h00);
    end
    n_checks++; if (done_q.size() != 1 || done_q[0] != n + 161 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done: pulses=%0d busy=%b want 1 at %0d, busy 0", done_q.size(), tx_busy, n + 161);
    end
  endtask

  task automatic test_idle_line();
    int bad;
    pulse_reset();
    clear_logs();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_line: %0d bad cycles want 0", bad); end
    n_checks++; if (f_data.size() != 0 || done_q.size() != 0) begin n_fail++; $display("FAIL idle_activity: frames=%0d pulses=%0d want 0,0", f_data.size(), done_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_idle_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- UART transmitter for the pipelined CPU, the transmit-side counterpart of the receive path that feeds the ID stage.
- Accepts result bytes from the CPU's peripheral write port into a small FIFO and serialises them as 8N1 frames on the uart_tx pin.
- Instantiated at the CPU top level; its line output drives uart_tx directly.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. Bit period DIV = CLK_FREQ/BAUD, integer-truncated (10416 at the defaults).
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  one-cycle write strobe from the CPU peripheral port.
- wr_data  input  8  byte to transmit; sampled when wr_en=1.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- tx_busy  output  1  FSM not in IDLE, or FIFO non-empty.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- overflow  output  1  sticky; set when a write is dropped.
- uart_tx  output  1  serial line; idle high; registered output.

Behaviour:
- Reset, asserted at any time including mid-frame:
  - uart_tx=1, full=0, tx_busy=0, tx_done=0, overflow=0.
  - FIFO emptied; FSM returns to IDLE; baud counter and bit index cleared.
  - Any partial frame is abandoned; the line returns high immediately (asynchronous).
- FIFO write:
  - When wr_en=1 and not full, wr_data is pushed at the clock edge.
  - When wr_en=1 and full with no pop in the same cycle, the byte is dropped and overflow is set until reset.
  - When wr_en=1 and full with a pop in the same cycle, the write is accepted and full stays 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for DIV cycles; shift right and increment the bit index. After bit index 7 completes, go to STOP. Bits are sent LSB first.
  - STOP: uart_tx=1 for DIV cycles. In the final cycle, assert tx_done. If the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Width is clog2(DIV).
  - Counts 0..DIV-1; the terminal count advances the FSM.
  - Every line bit lasts exactly DIV cycles; a frame is 10*DIV cycles.
- Latency: wr_en at cycle N into an empty, idle unit -> FIFO non-empty at N+1 -> pop and START at N+1 -> uart_tx low from cycle N+2.
- Line timing: uart_tx changes only on baud-counter terminal-count boundaries, plus the START entry from IDLE/STOP. It is driven from a flop and never glitches.
- FIFO pointers:
  - log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB comparison.
  - full and empty are derived combinationally from the pointers.
- tx_busy falls in the cycle after the last STOP, provided the FIFO is empty.

Decomposition:
- Shared package uart_pkg:
  - frame constants: DATA_BITS=8, STOP_BITS=1, IDLE_LEVEL=1'b1;
  - FSM state enum, tx_state_t {IDLE, START, DATA, STOP};
  - a DIV-computation function, shared with the future receiver.
- One sub-module: uart_tx_fifo, a synchronous byte FIFO with push/pop/full/empty, parameterised by FIFO_DEPTH.
- FSM, baud counter and shift register stay in uart_tx_unit.

Test Plan (CLK_FREQ=16, BAUD=1 so DIV=16, FIFO_DEPTH=4):
- Single byte: write 0x55 at cycle 10 -> uart_tx low from cycle 12, then 1,0,1,0,1,0,1,0 in 16-cycle bits, then stop high. tx_done pulses at cycle 171; tx_busy drops at cycle 172.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two frames with no idle gap; the second start bit begins the cycle after the first STOP ends; two tx_done pulses 160 cycles apart.
- Overflow: with the FSM holding 0x01 in flight, write 5 more bytes 0x02..0x06 on consecutive cycles -> full=1 after the 4th queued byte, the 5th (0x06) is dropped, overflow=1 and sticky. Frames 0x01..0x05 are transmitted in order.
- Full with simultaneous pop: FIFO full and a write coincides with the STOP->START pop -> write accepted, full remains 1, no overflow.
- Reset mid-frame: assert rst during DATA bit 3 of 0xF0 -> uart_tx=1 immediately (asynchronous), all outputs at reset values. After release, a new write of 0x81 produces a clean complete frame.
- Idle line: no writes for 500 cycles after reset -> uart_tx constant 1, tx_busy=0, tx_done never asserted.
